// File: rtl/calendar_counter.sv
// Calendar date register (day/month/year) advanced by a daily tick and six
// edge-detected adjust buttons. Optional macro CAL_DAY_CARRY_EN makes inc_d/dec_d carry into month/year.
module calendar_counter #(
  parameter int YEAR_W    = 14,
  parameter int YEAR_MIN  = 1,
  parameter int YEAR_MAX  = 9999,
  parameter int RST_YEAR  = 2018,
  parameter int RST_MONTH = 12,
  parameter int RST_DAY   = 5
) (
  input  logic              clk1000,
  input  logic              rst,
  input  logic              tick,
  input  logic              inc_y,
  input  logic              dec_y,
  input  logic              inc_mo,
  input  logic              dec_mo,
  input  logic              inc_d,
  input  logic              dec_d,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              leap,
  output logic [4:0]        dim,
  output logic              year_wrap
);

  localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);

  // Button vector order doubles as service priority (bit 0 first).
  localparam int B_INC_Y  = 0;
  localparam int B_DEC_Y  = 1;
  localparam int B_INC_MO = 2;
  localparam int B_DEC_MO = 3;
  localparam int B_INC_D  = 4;
  localparam int B_DEC_D  = 5;

  logic [5:0]        btn;
  logic [5:0]        btn_prev;
  logic [5:0]        pend;
  logic [5:0]        eff;
  logic [5:0]        served;
  logic [5:0]        pend_nxt;
  logic [4:0]        day_nxt;
  logic [3:0]        month_nxt;
  logic [YEAR_W-1:0] year_nxt;
  logic              wrap_nxt;
  logic [3:0]        m_tmp;
  logic [YEAR_W-1:0] y_tmp;

  function automatic logic leap_of(input logic [YEAR_W-1:0] y);
    int unsigned yi;
    yi = 32'(y);
    return ((yi % 4) == 0) && (((yi % 100) != 0) || ((yi % 400) == 0));
  endfunction

  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic lp);
    logic [4:0] r;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: r = 5'd30;
      4'd2:                    r = lp ? 5'd29 : 5'd28;
      default:                 r = 5'd31;
    endcase
    return r;
  endfunction

  function automatic logic [YEAR_W-1:0] yr_inc(input logic [YEAR_W-1:0] y);
    return (y == Y_MAX) ? Y_MIN : y + YEAR_W'(1);
  endfunction

  function automatic logic [YEAR_W-1:0] yr_dec(input logic [YEAR_W-1:0] y);
    return (y == Y_MIN) ? Y_MAX : y - YEAR_W'(1);
  endfunction

  function automatic logic [3:0] mo_inc(input logic [3:0] m);
    return (m == 4'd12) ? 4'd1 : m + 4'd1;
  endfunction

  function automatic logic [3:0] mo_dec(input logic [3:0] m);
    return (m == 4'd1) ? 4'd12 : m - 4'd1;
  endfunction

  function automatic logic [4:0] clamp(input logic [4:0] d, input logic [4:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  assign btn  = {dec_d, inc_d, dec_mo, inc_mo, dec_y, inc_y};
  assign leap = leap_of(year);
  assign dim  = dim_of(month, leap);

  always_comb begin
    // A release in the same cycle as an already-pending flag merges into one event.
    eff       = pend | (btn_prev & ~btn);
    served    = '0;
    day_nxt   = day;
    month_nxt = month;
    year_nxt  = year;
    wrap_nxt  = 1'b0;
    m_tmp     = month;
    y_tmp     = year;
    if (tick) begin
      if (day < dim) begin
        day_nxt = day + 5'd1;
      end else begin
        day_nxt = 5'd1;
        if (month == 4'd12) begin
          month_nxt = 4'd1;
          year_nxt  = yr_inc(year);
          wrap_nxt  = 1'b1;
        end else begin
          month_nxt = month + 4'd1;
        end
      end
    end else if (eff[B_INC_Y] || eff[B_DEC_Y]) begin
      if (eff[B_INC_Y]) begin
        served[B_INC_Y] = 1'b1;
        y_tmp           = yr_inc(year);
      end else begin
        served[B_DEC_Y] = 1'b1;
        y_tmp           = yr_dec(year);
      end
      year_nxt = y_tmp;
      day_nxt  = clamp(day, dim_of(month, leap_of(y_tmp)));
    end else if (eff[B_INC_MO] || eff[B_DEC_MO]) begin
      if (eff[B_INC_MO]) begin
        served[B_INC_MO] = 1'b1;
        m_tmp            = mo_inc(month);
      end else begin
        served[B_DEC_MO] = 1'b1;
        m_tmp            = mo_dec(month);
      end
      month_nxt = m_tmp;
      day_nxt   = clamp(day, dim_of(m_tmp, leap));
    end else if (eff[B_INC_D]) begin
      served[B_INC_D] = 1'b1;
      if (day < dim) begin
        day_nxt = day + 5'd1;
      end else begin
        day_nxt = 5'd1;
`ifdef CAL_DAY_CARRY_EN
        month_nxt = mo_inc(month);
        year_nxt  = (month == 4'd12) ? yr_inc(year) : year;
`endif
      end
    end else if (eff[B_DEC_D]) begin
      served[B_DEC_D] = 1'b1;
      if (day > 5'd1) begin
        day_nxt = day - 5'd1;
      end else begin
`ifdef CAL_DAY_CARRY_EN
        m_tmp     = mo_dec(month);
        y_tmp     = (month == 4'd1) ? yr_dec(year) : year;
        month_nxt = m_tmp;
        year_nxt  = y_tmp;
        day_nxt   = dim_of(m_tmp, leap_of(y_tmp));
`else
        day_nxt = dim;
`endif
      end
    end
    pend_nxt = eff & ~served;
  end

  always_ff @(posedge clk1000 or negedge rst) begin
    if (!rst) begin
      day       <= 5'(RST_DAY);
      month     <= 4'(RST_MONTH);
      year      <= YEAR_W'(RST_YEAR);
      year_wrap <= 1'b0;
      pend      <= '0;
      btn_prev  <= '0;
    end else begin
      day       <= day_nxt;
      month     <= month_nxt;
      year      <= year_nxt;
      year_wrap <= wrap_nxt;
      pend      <= pend_nxt;
      btn_prev  <= btn;
    end
  end

endmodule

// File: tb/tb_calendar_counter.sv
// Randomized and directed bench for calendar_counter against an integer date model.
`timescale 1ns/1ps
module tb_calendar_counter;

  logic        clk1000 = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        inc_y = 1'b0, dec_y = 1'b0, inc_mo = 1'b0, dec_mo = 1'b0, inc_d = 1'b0, dec_d = 1'b0;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [13:0] year;
  logic        leap;
  logic [4:0]  dim;
  logic        year_wrap;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: plain integers and flag arrays.
  int       m_d, m_m, m_y, m_wrap;
  bit [5:0] m_pend, m_prev;

  calendar_counter dut (
    .clk1000(clk1000), .rst(rst), .tick(tick),
    .inc_y(inc_y), .dec_y(dec_y), .inc_mo(inc_mo), .dec_mo(dec_mo),
    .inc_d(inc_d), .dec_d(dec_d),
    .day(day), .month(month), .year(year), .leap(leap), .dim(dim),
    .year_wrap(year_wrap)
  );

  always #5 clk1000 = ~clk1000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int f_leap(input int y);
    return ((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0))) ? 1 : 0;
  endfunction

  function automatic int f_dim(input int y, input int m);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    return (m == 2) ? 28 + f_leap(y) : tbl[m-1];
  endfunction

  function automatic int y_next(input int y);
    return (y == 9999) ? 1 : y + 1;
  endfunction

  function automatic int y_prev(input int y);
    return (y == 1) ? 9999 : y - 1;
  endfunction

  task automatic model_reset();
    m_d = 5; m_m = 12; m_y = 2018; m_wrap = 0; m_pend = '0; m_prev = '0;
  endtask

  // b: {dec_d, inc_d, dec_mo, inc_mo, dec_y, inc_y}
  task automatic model_edge(input bit t, input bit [5:0] b);
    bit [5:0] eff;
    int act;
    eff = m_pend | (m_prev & ~b);
    m_prev = b;
    m_wrap = 0;
    act = -1;
    if (t) act = 6;
    else for (int i = 0; i < 6; i++) if (act < 0 && eff[i]) act = i;
    if (act >= 0 && act < 6) eff[act] = 1'b0;
    m_pend = eff;
    case (act)
      6: begin
        m_d++;
        if (m_d > f_dim(m_y, m_m)) begin
          m_d = 1; m_m++;
          if (m_m > 12) begin m_m = 1; m_y = y_next(m_y); m_wrap = 1; end
        end
      end
      0: m_y = y_next(m_y);
      1: m_y = y_prev(m_y);
      2: m_m = (m_m % 12) + 1;
      3: m_m = ((m_m + 10) % 12) + 1;
      4: begin
        m_d++;
        if (m_d > f_dim(m_y, m_m)) begin
          m_d = 1;
`ifdef CAL_DAY_CARRY_EN
          m_m++;
          if (m_m > 12) begin m_m = 1; m_y = y_next(m_y); end
`endif
        end
      end
      5: begin
        m_d--;
        if (m_d == 0) begin
`ifdef CAL_DAY_CARRY_EN
          m_m--;
          if (m_m == 0) begin m_m = 12; m_y = y_prev(m_y); end
`endif
          m_d = f_dim(m_y, m_m);
        end
      end
      default: ;
    endcase
    if (m_d > f_dim(m_y, m_m)) m_d = f_dim(m_y, m_m);
  endtask

  task automatic compare_all();
    check("day", 32'(day), m_d);
    check("month", 32'(month), m_m);
    check("year", 32'(year), m_y);
    check("leap", 32'(leap), f_leap(m_y));
    check("dim", 32'(dim), f_dim(m_y, m_m));
    check("year_wrap", 32'(year_wrap), m_wrap);
  endtask

  // Drive one cycle of inputs, advance model at the edge, compare just after.
  task automatic step(input bit t, input bit [5:0] b);
    tick = t;
    {dec_d, inc_d, dec_mo, inc_mo, dec_y, inc_y} = b;
    @(posedge clk1000);
    model_edge(t, b);
    #1;
    compare_all();
  endtask

  task automatic press(input int idx);
    step(1'b0, 6'b000001 << idx);
    step(1'b0, 6'b000000);
  endtask

  task automatic check_date(input string tag, input int y, input int mo, input int d);
    check({tag, "_y"}, 32'(year), y);
    check({tag, "_m"}, 32'(month), mo);
    check({tag, "_d"}, 32'(day), d);
  endtask

  initial begin
    bit [5:0] cur_b;
    bit [5:0] mask;
    model_reset();
    repeat (3) @(posedge clk1000);
    #1;
    check_date("reset", 2018, 12, 5);
    check("reset_leap", 32'(leap), 0);
    check("reset_dim", 32'(dim), 31);
    check("reset_wrap", 32'(year_wrap), 0);
    @(negedge clk1000);
    rst = 1'b1;

    // Dec 31 roll-over and one-cycle year_wrap
    repeat (26) press(4);
    check_date("dec31", 2018, 12, 31);
    step(1'b1, 6'b0);
    check_date("newyear", 2019, 1, 1);
    check("wrap_hi", 32'(year_wrap), 1);
    step(1'b0, 6'b0);
    check("wrap_lo", 32'(year_wrap), 0);

    // Leap February ticks
    press(0);
    press(2);
    repeat (27) press(4);
    check_date("feb28", 2020, 2, 28);
    step(1'b1, 6'b0);
    check_date("feb29", 2020, 2, 29);
    step(1'b1, 6'b0);
    check_date("mar01", 2020, 3, 1);

    // Month and year clamping
    press(3);
    press(3);
    repeat (30) press(4);
    check_date("jan31", 2020, 1, 31);
    press(2);
    check_date("clamp_mo", 2020, 2, 29);
    press(0);
    check_date("clamp_y", 2021, 2, 28);

    // Century leap rules
    repeat (21) press(1);
    check("leap2000", 32'(leap), 1);
    repeat (100) press(1);
    check("leap1900", 32'(leap), 0);
    check("dim1900", 32'(dim), 28);

    // dec_d at the first of the month
    repeat (119) press(0);
    press(2);
    repeat (27) press(5);
    check_date("mar01_19", 2019, 3, 1);
    press(5);
`ifdef CAL_DAY_CARRY_EN
    check_date("dec_d_carry", 2019, 2, 28);
`else
    check_date("dec_d_wrap", 2019, 3, 31);
`endif

    // Year wrap at both ends
    for (int k = 0; k < 3000 && m_y != 1; k++) press(1);
    check("year_min", 32'(year), 1);
    press(1);
    check("year_to_max", 32'(year), 9999);
    press(0);
    check("year_to_min", 32'(year), 1);

    // Tick beats a simultaneous inc_d release; inc_d served next cycle
    step(1'b0, 6'b010000);
    step(1'b1, 6'b000000);
    step(1'b0, 6'b000000);

    // Random tick and button activity
    cur_b = '0;
    for (int i = 0; i < 3000; i++) begin
      mask = '0;
      for (int j = 0; j < 6; j++) mask[j] = ($urandom_range(0, 3) == 0);
      cur_b = cur_b ^ mask;
      step($urandom_range(0, 5) == 0, cur_b);
    end
    step(1'b0, 6'b0);

    // Reset with every flag pending: nothing may be applied afterwards
    step(1'b0, 6'b111111);
    step(1'b1, 6'b000000);
    rst = 1'b0;
    #1;
    model_reset();
    check_date("midreset", 2018, 12, 5);
    check("midreset_wrap", 32'(year_wrap), 0);
    @(negedge clk1000);
    rst = 1'b1;
    repeat (8) step(1'b0, 6'b0);
    check_date("after_reset", 2018, 12, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
